sram_responder: RTL and testbench

Synthesizable responder for the async SRAM pin interface (addr/data bus, ce_n/oe_n/we_n). It emulates an SRAM chip in block RAM, so the SRAM tester can be looped back against a second FPGA or exercised in simulation without a physical part. All pin inputs are asynchronous to clk and pass through synchronizers. The tri-state data pad lives at top level; this block supplies data_out and data_oe.

---
 rtl/sram_responder.sv | 159 +++++++++++++++
 tb/tb_sram_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// Block-RAM emulation of an asynchronous SRAM chip behind synchronized pin inputs.
// Reads go through a one-cycle BRAM stage; writes commit when WE/CE is released.
module sram_responder #(
    parameter int unsigned EXT_ADDR_BITS = 20,
    parameter int unsigned ADDR_BITS     = 10,
    parameter int unsigned DATA_BITS     = 16,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [EXT_ADDR_BITS-1:0] addr_bus,
    input  logic [DATA_BITS-1:0]     data_in,
    output logic [DATA_BITS-1:0]     data_out,
    output logic                     data_oe,
    input  logic                     ce_n,
    input  logic                     oe_n,
    input  logic                     we_n,
    output logic [15:0]              write_count,
    output logic [15:0]              read_count,
    output logic [ADDR_BITS-1:0]     last_write_addr
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR_ACTIVE} state_t;

    logic [EXT_ADDR_BITS-1:0] addr_sync [SYNC_STAGES];
    logic [DATA_BITS-1:0]     data_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0]   ce_sync, oe_sync, we_sync;

    logic [EXT_ADDR_BITS-1:0] addr_s;
    logic [ADDR_BITS-1:0]     addr_lo;
    logic [DATA_BITS-1:0]     data_s;
    logic                     ce_s, oe_s, we_s;
    logic                     rd_req, wr_act;
    logic                     unused_addr_hi;

    state_t                   state, state_d;
    logic                     mem_re, mem_we, load_out;
    logic                     data_oe_q;
    logic [ADDR_BITS-1:0]     rd_addr, wr_addr;
    logic [DATA_BITS-1:0]     wr_data, rd_q;
    logic [DATA_BITS-1:0]     mem [2**ADDR_BITS];

    // All pins share the same chain depth so the synced bus stays coherent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                addr_sync[i] <= '0;
                data_sync[i] <= '0;
            end
            ce_sync <= '1;
            oe_sync <= '1;
            we_sync <= '1;
        end else begin
            addr_sync[0] <= addr_bus;
            data_sync[0] <= data_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                addr_sync[i] <= addr_sync[i-1];
                data_sync[i] <= data_sync[i-1];
            end
            ce_sync <= {ce_sync[SYNC_STAGES-2:0], ce_n};
            oe_sync <= {oe_sync[SYNC_STAGES-2:0], oe_n};
            we_sync <= {we_sync[SYNC_STAGES-2:0], we_n};
        end
    end

    assign addr_s         = addr_sync[SYNC_STAGES-1];
    assign data_s         = data_sync[SYNC_STAGES-1];
    assign ce_s           = ce_sync[SYNC_STAGES-1];
    assign oe_s           = oe_sync[SYNC_STAGES-1];
    assign we_s           = we_sync[SYNC_STAGES-1];
    assign addr_lo        = addr_s[ADDR_BITS-1:0];
    assign unused_addr_hi = ^addr_s[EXT_ADDR_BITS-1:ADDR_BITS];

    assign rd_req = !ce_s && !oe_s && we_s;
    assign wr_act = !ce_s && !we_s;

    always_comb begin
        state_d  = state;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        load_out = 1'b0;
        case (state)
            IDLE: begin
                if (wr_act) begin
                    state_d = WR_ACTIVE;
                end else if (rd_req) begin
                    mem_re  = 1'b1;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (wr_act) begin
                    state_d = WR_ACTIVE;
                end else begin
                    load_out = 1'b1;
                    state_d  = RD_DRIVE;
                end
            end
            RD_DRIVE: begin
                if (wr_act) begin
                    state_d = WR_ACTIVE;
                end else if (!rd_req) begin
                    state_d = IDLE;
                end else if (addr_lo != rd_addr) begin
                    mem_re  = 1'b1;
                    state_d = RD_WAIT;
                end
            end
            WR_ACTIVE: begin
                if (!wr_act) begin
                    mem_we  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_addr] <= wr_data;
        if (mem_re) rd_q <= mem[addr_lo];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            data_oe_q       <= 1'b0;
            data_out        <= '0;
            rd_addr         <= '0;
            wr_addr         <= '0;
            wr_data         <= '0;
            write_count     <= '0;
            read_count      <= '0;
            last_write_addr <= '0;
        end else begin
            state     <= state_d;
            data_oe_q <= (state_d == RD_DRIVE);
            if (mem_re) rd_addr <= addr_lo;
            if (load_out) begin
                data_out   <= rd_q;
                read_count <= read_count + 16'd1;
            end
            // Track the bus while the write is live; the last live cycle is what commits.
            if (wr_act) begin
                wr_addr <= addr_lo;
                wr_data <= data_s;
            end
            if (mem_we) begin
                write_count     <= write_count + 16'd1;
                last_write_addr <= wr_addr;
            end
        end
    end

    // Registered enable, but it drops combinationally as soon as the synced read request goes away
    // (including a write taking the bus), so the pad is released in the same cycle.
    assign data_oe = data_oe_q && rd_req;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed scenarios plus randomized
// write/read traffic checked against an array model of the emulated SRAM.
module tb_sram_responder;

    localparam int unsigned EXT_ADDR_BITS = 20;
    localparam int unsigned ADDR_BITS     = 10;
    localparam int unsigned DATA_BITS     = 16;
    localparam int unsigned SYNC_STAGES   = 2;
    localparam int unsigned DEPTH         = 1 << ADDR_BITS;
    localparam int unsigned RD_LAT        = SYNC_STAGES + 2;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [EXT_ADDR_BITS-1:0] addr_bus;
    logic [DATA_BITS-1:0]     data_in;
    logic [DATA_BITS-1:0]     data_out;
    logic                     data_oe;
    logic                     ce_n, oe_n, we_n;
    logic [15:0]              write_count, read_count;
    logic [ADDR_BITS-1:0]     last_write_addr;

    sram_responder #(
        .EXT_ADDR_BITS(EXT_ADDR_BITS),
        .ADDR_BITS    (ADDR_BITS),
        .DATA_BITS    (DATA_BITS),
        .SYNC_STAGES  (SYNC_STAGES)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .addr_bus       (addr_bus),
        .data_in        (data_in),
        .data_out       (data_out),
        .data_oe        (data_oe),
        .ce_n           (ce_n),
        .oe_n           (oe_n),
        .we_n           (we_n),
        .write_count    (write_count),
        .read_count     (read_count),
        .last_write_addr(last_write_addr)
    );

    always #5 clk = ~clk;

    // Reference model: word array indexed modulo the emulated depth, plus counters.
    logic [DATA_BITS-1:0] mdl [DEPTH];
    bit                   vld [DEPTH];
    int unsigned          exp_wc, exp_rc;
    logic [ADDR_BITS-1:0] exp_lwa;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        ce_n = 1'b1;
        oe_n = 1'b1;
        we_n = 1'b1;
    endtask

    task automatic do_write(input logic [EXT_ADDR_BITS-1:0] a, input logic [DATA_BITS-1:0] d,
                            input int unsigned len);
        addr_bus = a;
        data_in  = d;
        oe_n     = 1'b1;
        ce_n     = 1'b0;
        we_n     = 1'b0;
        repeat (len) step();
        bus_idle();
        repeat (SYNC_STAGES + 3) step();
        mdl[a % DEPTH] = d;
        vld[a % DEPTH] = 1'b1;
        exp_wc++;
        exp_lwa = ADDR_BITS'(a % DEPTH);
    endtask

    // Starts a read and leaves the bus in the read phase once data is driven.
    task automatic start_read(input logic [EXT_ADDR_BITS-1:0] a, input string tag);
        int unsigned lat;
        addr_bus = a;
        we_n     = 1'b1;
        ce_n     = 1'b0;
        oe_n     = 1'b0;
        lat      = 0;
        while (data_oe !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, RD_LAT);
        check({tag, "_data"}, data_out, mdl[a % DEPTH]);
        exp_rc++;
    endtask

    task automatic end_read(input string tag);
        bus_idle();
        repeat (SYNC_STAGES + 2) step();
        check({tag, "_release"}, data_oe, 1'b0);
    endtask

    task automatic do_read(input logic [EXT_ADDR_BITS-1:0] a, input string tag);
        start_read(a, tag);
        end_read(tag);
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        repeat (2) step();
        exp_wc  = 0;
        exp_rc  = 0;
        exp_lwa = '0;
    endtask

    initial begin
        int unsigned          low;
        logic [EXT_ADDR_BITS-1:0] ra;
        logic [DATA_BITS-1:0]     rd;

        for (int i = 0; i < int'(DEPTH); i++) begin
            mdl[i] = '0;
            vld[i] = 1'b0;
        end
        exp_wc  = 0;
        exp_rc  = 0;
        exp_lwa = '0;

        // Reset held with a read request on the pins.
        reset_n  = 1'b0;
        addr_bus = '0;
        data_in  = '0;
        ce_n     = 1'b0;
        oe_n     = 1'b0;
        we_n     = 1'b1;
        repeat (3) step();
        check("rst_data_oe", data_oe, 1'b0);
        check("rst_write_count", write_count, 16'd0);
        check("rst_read_count", read_count, 16'd0);
        check("rst_last_write_addr", last_write_addr, '0);
        check("rst_data_out", data_out, '0);
        reset_n = 1'b1;
        for (int i = 0; i < int'(SYNC_STAGES) + 1; i++) begin
            step();
            check("rst_release_oe_low", data_oe, 1'b0);
        end
        step();
        check("rst_release_oe_rise", data_oe, 1'b1);
        bus_idle();
        step();
        reset_pulse();

        // Write then read.
        do_write(20'h00012, 16'hA5C3, 4);
        check("wr1_write_count", write_count, 16'd1);
        check("wr1_last_write_addr", last_write_addr, 10'h012);
        do_read(20'h00012, "rd1");
        check("rd1_read_count", read_count, 16'd1);

        // Upper address bits are ignored.
        do_write(20'h00400, 16'h1234, 3);
        check("alias_last_write_addr", last_write_addr, 10'h000);
        do_read(20'h00000, "alias");

        // Address change while driving.
        do_write(20'h00005, 16'h1111, 2);
        do_write(20'h00006, 16'h2222, 2);
        start_read(20'h00005, "achg0");
        addr_bus = 20'h00006;
        low = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (data_oe == 1'b0) low++;
        end
        exp_rc++;
        check("achg_low_cycles", low, 1);
        check("achg_data", data_out, 16'h2222);
        check("achg_oe", data_oe, 1'b1);
        check("achg_read_count", read_count, 16'(exp_rc));
        end_read("achg");

        // Write takes the bus while a read is being driven.
        do_write(20'h000C0, 16'h0F0F, 2);
        start_read(20'h000C0, "cont");
        addr_bus = 20'h000C1;
        data_in  = 16'h7E7E;
        we_n     = 1'b0;
        step();
        check("cont_oe_before_sync", data_oe, 1'b1);
        step();
        check("cont_oe_drop", data_oe, 1'b0);
        repeat (3) step();
        check("cont_oe_held_low", data_oe, 1'b0);
        check("cont_no_early_commit", write_count, 16'(exp_wc));
        bus_idle();
        repeat (SYNC_STAGES + 3) step();
        mdl[10'h0C1] = 16'h7E7E;
        vld[10'h0C1] = 1'b1;
        exp_wc++;
        exp_lwa = 10'h0C1;
        check("cont_write_count", write_count, 16'(exp_wc));
        check("cont_last_write_addr", last_write_addr, exp_lwa);
        do_read(20'h000C1, "cont_rb");

        // Reset during an active write drops it.
        do_write(20'h000AB, 16'h5555, 3);
        addr_bus = 20'h000AB;
        data_in  = 16'hDEAD;
        ce_n     = 1'b0;
        we_n     = 1'b0;
        repeat (4) step();
        reset_n = 1'b0;
        step();
        check("rstw_write_count_async", write_count, 16'd0);
        bus_idle();
        repeat (2) step();
        reset_n = 1'b1;
        repeat (3) step();
        exp_wc  = 0;
        exp_rc  = 0;
        exp_lwa = '0;
        check("rstw_write_count", write_count, 16'd0);
        do_read(20'h000AB, "rstw_rb");

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            ra = EXT_ADDR_BITS'($urandom);
            rd = DATA_BITS'($urandom);
            if ($urandom_range(0, 1) == 0 || !vld[ra % DEPTH])
                do_write(ra, rd, $urandom_range(2, 5));
            else
                do_read(ra, "rand_rd");
        end
        check("final_write_count", write_count, 16'(exp_wc));
        check("final_read_count", read_count, 16'(exp_rc));
        check("final_last_write_addr", last_write_addr, exp_lwa);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
